// File: rtl/dmem_access_seq.sv
// Load/store sequencer between the memory stage and a byte-banked data memory.
// Aligned requests issue one native access; misaligned ones are split into lw pairs or sb runs.
module dmem_access_seq #(
  parameter int unsigned ADDR_W      = 12,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  output logic              mem_sb,
  output logic              mem_sh,
  output logic              mem_sw,
  output logic              mem_lb,
  output logic              mem_lbu,
  output logic              mem_lh,
  output logic              mem_lhu,
  output logic              mem_lw,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, ISSUE, LD_LO, LD_HI, ST_BYTE, RESP} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic                we_q;
  logic                uns_q;
  logic [31:0]         wdata_q;
  logic [31:0]         lo_q;
  logic [1:0]          k_q;

  logic                misalign_d;
  logic [1:0]          k_d;
  logic                last_byte_d;
  logic [ADDR_W-1:0]   byte_addr_d;
  logic [7:0]          byte_d;
  logic [ADDR_W-1:0]   hi_addr_d;
  logic [31:0]         pair_d;
  logic [31:0]         merged_d;

  always_comb begin
    misalign_d  = (cpu_size == 2'd1 && cpu_addr[0]) ||
                  (cpu_size == 2'd2 && cpu_addr[1:0] != 2'b00);
    k_d         = k_q + 2'd1;
    last_byte_d = (size_q == 2'd1) ? (k_q == 2'd1) : (k_q == 2'd3);
    byte_addr_d = addr_q + ADDR_W'(k_d);
    byte_d      = wdata_q[{k_d, 3'b000} +: 8];
    hi_addr_d   = {addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00};
    // mem_rdata carries the high word during LD_HI; shift the pair down to the requested byte
    pair_d      = 32'({mem_rdata, lo_q} >> {addr_q[1:0], 3'b000});
    if (size_q == 2'd1) merged_d = {{16{~uns_q & pair_d[15]}}, pair_d[15:0]};
    else                merged_d = pair_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cpu_ready <= 1'b1;
      cpu_done  <= 1'b0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_sb    <= 1'b0;
      mem_sh    <= 1'b0;
      mem_sw    <= 1'b0;
      mem_lb    <= 1'b0;
      mem_lbu   <= 1'b0;
      mem_lh    <= 1'b0;
      mem_lhu   <= 1'b0;
      mem_lw    <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      lo_q      <= '0;
      k_q       <= '0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_sb    <= 1'b0;
      mem_sh    <= 1'b0;
      mem_sw    <= 1'b0;
      mem_lb    <= 1'b0;
      mem_lbu   <= 1'b0;
      mem_lh    <= 1'b0;
      mem_lhu   <= 1'b0;
      mem_lw    <= 1'b0;
      case (state_q)
        IDLE: begin
          cpu_ready <= 1'b1;
          if (cpu_req) begin
            cpu_ready <= 1'b0;
            addr_q    <= cpu_addr;
            size_q    <= cpu_size;
            we_q      <= cpu_we;
            uns_q     <= cpu_unsigned;
            wdata_q   <= cpu_wdata;
            k_q       <= '0;
            if (cpu_size == 2'd3 || (misalign_d && !MISALIGN_EN)) begin
              state_q  <= RESP;
              cpu_done <= 1'b1;
              cpu_err  <= 1'b1;
            end else if (!misalign_d) begin
              state_q  <= ISSUE;
              mem_addr <= cpu_addr;
              if (cpu_we) begin
                mem_write <= 1'b1;
                mem_wdata <= cpu_wdata;
                mem_sb    <= (cpu_size == 2'd0);
                mem_sh    <= (cpu_size == 2'd1);
                mem_sw    <= (cpu_size == 2'd2);
              end else begin
                mem_lb  <= (cpu_size == 2'd0) && !cpu_unsigned;
                mem_lbu <= (cpu_size == 2'd0) &&  cpu_unsigned;
                mem_lh  <= (cpu_size == 2'd1) && !cpu_unsigned;
                mem_lhu <= (cpu_size == 2'd1) &&  cpu_unsigned;
                mem_lw  <= (cpu_size == 2'd2);
              end
            end else if (cpu_we) begin
              state_q   <= ST_BYTE;
              mem_sb    <= 1'b1;
              mem_write <= 1'b1;
              mem_addr  <= cpu_addr;
              mem_wdata <= {24'b0, cpu_wdata[7:0]};
            end else begin
              state_q  <= LD_LO;
              mem_lw   <= 1'b1;
              mem_addr <= {cpu_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        ISSUE: begin
          state_q  <= RESP;
          cpu_done <= 1'b1;
          if (!we_q) cpu_rdata <= mem_rdata;
        end
        LD_LO: begin
          state_q  <= LD_HI;
          lo_q     <= mem_rdata;
          mem_lw   <= 1'b1;
          mem_addr <= hi_addr_d;
        end
        LD_HI: begin
          state_q   <= RESP;
          cpu_done  <= 1'b1;
          cpu_rdata <= merged_d;
        end
        ST_BYTE: begin
          if (last_byte_d) begin
            state_q  <= RESP;
            cpu_done <= 1'b1;
          end else begin
            k_q       <= k_d;
            mem_sb    <= 1'b1;
            mem_write <= 1'b1;
            mem_addr  <= byte_addr_d;
            mem_wdata <= {24'b0, byte_d};
          end
        end
        RESP: begin
          state_q   <= IDLE;
          cpu_ready <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          cpu_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
